// File: rtl/ec_scalar_mult_ctrl_pkg.sv
// Shared curve constants and controller state encoding for the scalar multiplier.
package ec_scalar_mult_ctrl_pkg;

    // Toy curve y^2 = x^3 + A*x + b over GF(P)
    localparam int DATAWIDTH = 8;
    localparam int P_INT     = 17;
    localparam int A_INT     = 2;

    localparam logic [DATAWIDTH-1:0] P_MOD    = DATAWIDTH'(P_INT);
    localparam logic [DATAWIDTH-1:0] A_MOD    = DATAWIDTH'(A_INT);
    localparam logic [DATAWIDTH-1:0] PT_INF_X = '0;
    localparam logic [DATAWIDTH-1:0] PT_INF_Y = '0;

    // Two-bit binary encoding of the double-and-add sequencer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DBL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/ec_scalar_mult_ctrl_point_adder.sv
// Combinational affine point adder over GF(P_MOD); (0,0) encodes the point at infinity.
// Handles P+O, O+Q, P+(-P), doubling (including y=0) and general addition.
module ec_scalar_mult_ctrl_point_adder
    import ec_scalar_mult_ctrl_pkg::*;
(
    input  logic [DATAWIDTH-1:0] x1,
    input  logic [DATAWIDTH-1:0] y1,
    input  logic [DATAWIDTH-1:0] x2,
    input  logic [DATAWIDTH-1:0] y2,
    output logic [DATAWIDTH-1:0] x3,
    output logic [DATAWIDTH-1:0] y3
);

    localparam int W = DATAWIDTH;
    localparam logic [W-1:0] INV_EXP = W'(P_INT - 2);
    localparam logic [W-1:0] ONE     = W'(1);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P_MOD}) begin
            s = s - {1'b0, P_MOD};
        end
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = (P_MOD - b) + a;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] r;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r    = prod % {{W{1'b0}}, P_MOD};
        return r[W-1:0];
    endfunction

    // Fermat inverse a^(P-2); inverse of 0 comes out as 0 and is never selected.
    function automatic logic [W-1:0] mod_inv(input logic [W-1:0] a);
        logic [W-1:0] res;
        logic [W-1:0] base;
        res  = ONE;
        base = a;
        for (int i = 0; i < W; i++) begin
            if (INV_EXP[i]) begin
                res = mod_mul(res, base);
            end
            base = mod_mul(base, base);
        end
        return res;
    endfunction

    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] lam;
    logic [W-1:0] sq;
    logic [W-1:0] xr;

    // Select the special case, then evaluate the chord/tangent formula.
    always_comb begin
        sq  = mod_mul(x1, x1);
        num = '0;
        den = '0;
        lam = '0;
        xr  = '0;
        x3  = PT_INF_X;
        y3  = PT_INF_Y;
        if (x1 == PT_INF_X && y1 == PT_INF_Y) begin
            x3 = x2;
            y3 = y2;
        end else if (x2 == PT_INF_X && y2 == PT_INF_Y) begin
            x3 = x1;
            y3 = y1;
        end else if (x1 == x2 && (y1 != y2 || y1 == '0)) begin
            // P + (-P), or tangent through a point with y=0: infinity
            x3 = PT_INF_X;
            y3 = PT_INF_Y;
        end else begin
            if (x1 == x2) begin
                num = mod_add(mod_add(mod_add(sq, sq), sq), A_MOD);
                den = mod_add(y1, y1);
            end else begin
                num = mod_sub(y2, y1);
                den = mod_sub(x2, x1);
            end
            lam = mod_mul(num, mod_inv(den));
            xr  = mod_sub(mod_sub(mod_mul(lam, lam), x1), x2);
            x3  = xr;
            y3  = mod_sub(mod_mul(lam, mod_sub(x1, xr)), y1);
        end
    end

endmodule

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer computing R = k*P with one shared point adder.
// start/busy/done handshake; result coordinates are registered and held until the next done.
module ec_scalar_mult_ctrl
    import ec_scalar_mult_ctrl_pkg::*;
#(
    parameter int KWIDTH     = DATAWIDTH,
    parameter int CONST_TIME = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [KWIDTH-1:0]    k,
    input  logic [DATAWIDTH-1:0] Px,
    input  logic [DATAWIDTH-1:0] Py,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] Rx_out,
    output logic [DATAWIDTH-1:0] Ry_out
);

    localparam int IDX_W = (KWIDTH > 1) ? $clog2(KWIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(KWIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_e                state_q,  state_d;
    logic [KWIDTH-1:0]     k_q,      k_d;
    logic [DATAWIDTH-1:0]  px_q,     px_d;
    logic [DATAWIDTH-1:0]  py_q,     py_d;
    logic [DATAWIDTH-1:0]  rx_q,     rx_d;
    logic [DATAWIDTH-1:0]  ry_q,     ry_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DATAWIDTH-1:0]  rx_out_q, rx_out_d;
    logic [DATAWIDTH-1:0]  ry_out_q, ry_out_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;

    logic [DATAWIDTH-1:0]  add_x2;
    logic [DATAWIDTH-1:0]  add_y2;
    logic [DATAWIDTH-1:0]  sum_x;
    logic [DATAWIDTH-1:0]  sum_y;
    logic                  kbit;

    // Second adder operand: R itself while doubling, the captured base point otherwise.
    always_comb begin
        add_x2 = (state_q == ST_DBL) ? rx_q : px_q;
        add_y2 = (state_q == ST_DBL) ? ry_q : py_q;
    end

    ec_scalar_mult_ctrl_point_adder u_point_adder (
        .x1 (rx_q),
        .y1 (ry_q),
        .x2 (add_x2),
        .y2 (add_y2),
        .x3 (sum_x),
        .y3 (sum_y)
    );

    assign kbit = k_q[idx_q];

    // Next-state, accumulator and index update; outputs derive from the next state so they register cleanly.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        px_d     = px_q;
        py_d     = py_q;
        rx_d     = rx_q;
        ry_d     = ry_q;
        idx_d    = idx_q;
        rx_out_d = rx_out_q;
        ry_out_d = ry_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_d     = k;
                    px_d    = Px;
                    py_d    = Py;
                    rx_d    = PT_INF_X;
                    ry_d    = PT_INF_Y;
                    idx_d   = IDX_TOP;
                    state_d = ST_DBL;
                end
            end
            ST_DBL: begin
                rx_d = sum_x;
                ry_d = sum_y;
                if (CONST_TIME != 0 || kbit) begin
                    state_d = ST_ADD;
                end else if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    state_d = ST_DBL;
                end
            end
            ST_ADD: begin
                // The adder always runs; its result is kept only for a 1 bit.
                if (kbit) begin
                    rx_d = sum_x;
                    ry_d = sum_y;
                end
                if (idx_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    state_d = ST_DBL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_DONE) begin
            rx_out_d = rx_d;
            ry_out_d = ry_d;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // All controller state, with asynchronous abort to the reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            px_q     <= '0;
            py_q     <= '0;
            rx_q     <= '0;
            ry_q     <= '0;
            idx_q    <= '0;
            rx_out_q <= '0;
            ry_out_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            px_q     <= px_d;
            py_q     <= py_d;
            rx_q     <= rx_d;
            ry_q     <= ry_d;
            idx_q    <= idx_d;
            rx_out_q <= rx_out_d;
            ry_out_q <= ry_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Rx_out = rx_out_q;
    assign Ry_out = ry_out_q;

endmodule
